wb_regfile: RTL and testbench

- Write-back register file for the 5-stage MIPS pipeline. Sits directly downstream of the WB-stage control decoder.
- Consumes the decoder's RegWrite/MemtoReg/RegDst outputs plus the WB-stage instruction, PC, ALU result and memory read data.
- Resolves the destination register and write data, commits them to a 32x32 general register file, and serves the two ID-stage read ports with WB->ID bypass.
- Also exposes a registered commit trace port and a retired-write counter for verification.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/wb_select.sv | 45 ++++
 rtl/wb_regfile.sv | 104 ++++++++++
 tb/tb_wb_regfile.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings used by the write-back register file.
package mips_pkg;

  // Destination register select codes
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // Write-data select codes
  localparam logic [1:0] WBSEL_ALU  = 2'd0;
  localparam logic [1:0] WBSEL_MEM  = 2'd1;
  localparam logic [1:0] WBSEL_LINK = 2'd2;

  // Architectural register numbers
  localparam logic [4:0] REG_RA   = 5'd31;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Instruction field bit positions
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

endpackage

// File: rtl/wb_select.sv
// Write-back destination, data and enable resolution (purely combinational).
module wb_select
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LINK_OFFSET = 8
) (
  input  logic              wb_reg_write,
  input  logic [1:0]        wb_mem_to_reg,
  input  logic [1:0]        wb_reg_dst,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_rdata,
  output logic [4:0]        o_waddr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_we
);

  // Destination register; the reserved code maps to $0 so nothing is written
  always_comb begin
    o_waddr = REG_ZERO;
    case (wb_reg_dst)
      REGDST_RT: o_waddr = i_rt;
      REGDST_RD: o_waddr = i_rd;
      REGDST_RA: o_waddr = REG_RA;
      default:   o_waddr = REG_ZERO;
    endcase
  end

  // Write data; the link value wraps modulo 2^DATA_W
  always_comb begin
    o_wdata = '0;
    case (wb_mem_to_reg)
      WBSEL_ALU:  o_wdata = wb_alu_result;
      WBSEL_MEM:  o_wdata = wb_mem_rdata;
      WBSEL_LINK: o_wdata = wb_pc + DATA_W'(LINK_OFFSET);
      default:    o_wdata = '0;
    endcase
  end

  assign o_we = wb_reg_write && (o_waddr != REG_ZERO);

endmodule

// File: rtl/wb_regfile.sv
// Write-back register file: 32 GPRs, WB->ID bypass, forward and commit trace.
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NREG        = 32,
  parameter int LINK_OFFSET = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_reg_write,
  input  logic [1:0]        wb_mem_to_reg,
  input  logic [1:0]        wb_reg_dst,
  input  logic [31:0]       wb_instr,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_rdata,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              fwd_valid,
  output logic [4:0]        fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic              commit_valid,
  output logic [DATA_W-1:0] commit_pc,
  output logic [4:0]        commit_addr,
  output logic [DATA_W-1:0] commit_data,
  output logic [31:0]       commit_count
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic [4:0]        w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_we;
  logic              w_unused_instr;

  // Only the rt/rd fields matter here; the rest of the word is intentionally ignored
  assign w_unused_instr = ^{wb_instr[31:RT_MSB+1], wb_instr[RD_LSB-1:0]};

  wb_select #(
    .DATA_W      (DATA_W),
    .LINK_OFFSET (LINK_OFFSET)
  ) u_sel (
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_dst    (wb_reg_dst),
    .i_rt          (wb_instr[RT_MSB:RT_LSB]),
    .i_rd          (wb_instr[RD_MSB:RD_LSB]),
    .wb_pc         (wb_pc),
    .wb_alu_result (wb_alu_result),
    .wb_mem_rdata  (wb_mem_rdata),
    .o_waddr       (w_waddr),
    .o_wdata       (w_wdata),
    .o_we          (w_we)
  );

  assign fwd_valid = w_we;
  assign fwd_addr  = w_waddr;
  assign fwd_data  = w_wdata;

  // Register storage; reset wins over a write in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  // Read port 1: $0 reads zero, then same-cycle bypass, then storage
  always_comb begin
    rs_data = r_regs[rs_addr];
    if (rs_addr == REG_ZERO)                rs_data = '0;
    else if (w_we && (w_waddr == rs_addr))  rs_data = w_wdata;
  end

  // Read port 2: same priority as port 1
  always_comb begin
    rt_data = r_regs[rt_addr];
    if (rt_addr == REG_ZERO)                rt_data = '0;
    else if (w_we && (w_waddr == rt_addr))  rt_data = w_wdata;
  end

  // Commit trace: payload holds when no write retires; count wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_addr  <= '0;
      commit_data  <= '0;
      commit_count <= '0;
    end else begin
      commit_valid <= w_we;
      if (w_we) begin
        commit_pc    <= wb_pc;
        commit_addr  <= w_waddr;
        commit_data  <= w_wdata;
        commit_count <= commit_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic        clk;
  logic        reset;
  logic        wb_reg_write;
  logic [1:0]  wb_mem_to_reg;
  logic [1:0]  wb_reg_dst;
  logic [31:0] wb_instr;
  logic [31:0] wb_pc;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_mem_rdata;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_addr;
  logic [31:0] commit_data;
  logic [31:0] commit_count;

  int n_cmp;
  int n_fail;

  wb_regfile #(.DATA_W(32), .NREG(32), .LINK_OFFSET(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_reg_dst    (wb_reg_dst),
    .wb_instr      (wb_instr),
    .wb_pc         (wb_pc),
    .wb_alu_result (wb_alu_result),
    .wb_mem_rdata  (wb_mem_rdata),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .commit_valid  (commit_valid),
    .commit_pc     (commit_pc),
    .commit_addr   (commit_addr),
    .commit_data   (commit_data),
    .commit_count  (commit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_wb(input logic rw, input logic [1:0] m2r, input logic [1:0] dst,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] mem);
    wb_reg_write  = rw;
    wb_mem_to_reg = m2r;
    wb_reg_dst    = dst;
    wb_instr      = instr;
    wb_pc         = pc;
    wb_alu_result = alu;
    wb_mem_rdata  = mem;
  endtask

  task automatic bubble();
    set_wb(1'b0, 2'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Advance one edge, then drop the WB inputs to a bubble
  task automatic step();
    @(posedge clk);
    #1;
    bubble();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bubble();
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rs_addr = 5'd5;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_init_rs5 got=%h exp=%h", rs_data, 32'h0); end
    n_cmp++; if (commit_count !== 32'h0) begin n_fail++; $display("FAIL reset_init_count got=%h exp=%h", commit_count, 32'h0); end
    // write $5 then reset it away
    set_wb(1'b1, 2'd0, 2'd0, 32'h0005_0000, 32'h0000_0040, 32'h0000_1234, 32'h0);
    step();
    n_cmp++; if (rs_data !== 32'h0000_1234) begin n_fail++; $display("FAIL pre_reset_rs5 got=%h exp=%h", rs_data, 32'h1234); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL reset_rs5 got=%h exp=%h", rs_data, 32'h0); end
    n_cmp++; if (commit_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got=%h exp=%h", commit_count, 32'h0); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=%b", commit_valid, 1'b0); end
    n_cmp++; if (commit_addr !== 5'd0 || commit_data !== 32'h0 || commit_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_payload got=%0d/%h/%h exp=0/0/0", commit_addr, commit_data, commit_pc); end
  endtask

  task automatic test_ori();
    set_wb(1'b1, 2'd0, 2'd0, 32'h0008_5800, 32'h0000_0100, 32'h0000_FFFF, 32'h1111_2222);
    rs_addr = 5'd8;
    step();
    n_cmp++; if (rs_data !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ori_rs8 got=%h exp=%h", rs_data, 32'hFFFF); end
    n_cmp++; if (commit_valid !== 1'b1) begin n_fail++; $display("FAIL ori_valid got=%b exp=1", commit_valid); end
    n_cmp++; if (commit_addr !== 5'd8) begin n_fail++; $display("FAIL ori_caddr got=%0d exp=8", commit_addr); end
    n_cmp++; if (commit_data !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ori_cdata got=%h exp=%h", commit_data, 32'hFFFF); end
    n_cmp++; if (commit_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL ori_cpc got=%h exp=%h", commit_pc, 32'h100); end
    n_cmp++; if (commit_count !== 32'd1) begin n_fail++; $display("FAIL ori_count got=%0d exp=1", commit_count); end
    // rd field 11 was not the destination
    rt_addr = 5'd11;
    #1;
    n_cmp++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL ori_rd11_untouched got=%h exp=0", rt_data); end
  endtask

  task automatic test_jal();
    set_wb(1'b1, 2'd2, 2'd2, 32'h0C00_0C00, 32'h0000_3000, 32'h0BAD_0BAD, 32'h0);
    #1;
    n_cmp++; if (fwd_valid !== 1'b1) begin n_fail++; $display("FAIL jal_fwd_valid got=%b exp=1", fwd_valid); end
    n_cmp++; if (fwd_addr !== 5'd31) begin n_fail++; $display("FAIL jal_fwd_addr got=%0d exp=31", fwd_addr); end
    n_cmp++; if (fwd_data !== 32'h0000_3008) begin n_fail++; $display("FAIL jal_fwd_data got=%h exp=%h", fwd_data, 32'h3008); end
    step();
    rs_addr = 5'd31;
    #1;
    n_cmp++; if (rs_data !== 32'h0000_3008) begin n_fail++; $display("FAIL jal_r31 got=%h exp=%h", rs_data, 32'h3008); end
    n_cmp++; if (commit_count !== 32'd2) begin n_fail++; $display("FAIL jal_count got=%0d exp=2", commit_count); end
  endtask

  task automatic test_bypass();
    rs_addr = 5'd9;
    rt_addr = 5'd9;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL byp_pre_r9 got=%h exp=0", rs_data); end
    set_wb(1'b1, 2'd1, 2'd0, 32'h8C09_0000, 32'h0000_0200, 32'h1111_1111, 32'hDEAD_BEEF);
    #1;
    n_cmp++; if (rs_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL byp_rs got=%h exp=%h", rs_data, 32'hDEADBEEF); end
    n_cmp++; if (rt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL byp_rt got=%h exp=%h", rt_data, 32'hDEADBEEF); end
    rs_addr = 5'd8;
    #1;
    n_cmp++; if (rs_data !== 32'h0000_FFFF) begin n_fail++; $display("FAIL byp_other_rs8 got=%h exp=%h", rs_data, 32'hFFFF); end
    step();
    n_cmp++; if (rt_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL byp_stored_r9 got=%h exp=%h", rt_data, 32'hDEADBEEF); end
    n_cmp++; if (commit_count !== 32'd3) begin n_fail++; $display("FAIL byp_count got=%0d exp=3", commit_count); end
  endtask

  task automatic test_zero();
    set_wb(1'b1, 2'd0, 2'd1, 32'h0007_0000, 32'h0000_0300, 32'hFFFF_FFFF, 32'h0);
    rs_addr = 5'd0;
    rt_addr = 5'd7;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL zero_rs0 got=%h exp=0", rs_data); end
    n_cmp++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL zero_fwd_valid got=%b exp=0", fwd_valid); end
    step();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL zero_cvalid got=%b exp=0", commit_valid); end
    n_cmp++; if (commit_count !== 32'd3) begin n_fail++; $display("FAIL zero_count got=%0d exp=3", commit_count); end
    n_cmp++; if (commit_addr !== 5'd9 || commit_data !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL zero_hold got=%0d/%h exp=9/deadbeef", commit_addr, commit_data); end
    n_cmp++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL zero_r7 got=%h exp=0", rt_data); end
  endtask

  task automatic test_rd_and_reserved();
    // rd=12, rt field=3
    set_wb(1'b1, 2'd0, 2'd1, 32'h0003_6000, 32'h0000_0400, 32'hA5A5_5A5A, 32'h0);
    step();
    rs_addr = 5'd12;
    rt_addr = 5'd3;
    #1;
    n_cmp++; if (rs_data !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL rd_r12 got=%h exp=%h", rs_data, 32'hA5A55A5A); end
    n_cmp++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL rd_r3 got=%h exp=0", rt_data); end
    // reserved reg_dst: no write
    set_wb(1'b1, 2'd0, 2'd3, 32'h000A_6000, 32'h0000_0500, 32'h0000_0055, 32'h0);
    #1;
    n_cmp++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rsvd_dst_fwd got=%b exp=0", fwd_valid); end
    step();
    n_cmp++; if (rs_data !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL rsvd_dst_r12 got=%h exp=%h", rs_data, 32'hA5A55A5A); end
    // preload $10 then overwrite with reserved mem_to_reg (zero)
    set_wb(1'b1, 2'd0, 2'd0, 32'h000A_0000, 32'h0000_0600, 32'h0000_0055, 32'h0);
    step();
    set_wb(1'b1, 2'd3, 2'd0, 32'h000A_0000, 32'h0000_0604, 32'h0000_0066, 32'h0000_0077);
    rs_addr = 5'd10;
    #1;
    n_cmp++; if (fwd_valid !== 1'b1 || fwd_data !== 32'h0) begin
      n_fail++; $display("FAIL rsvd_sel_fwd got=%b/%h exp=1/0", fwd_valid, fwd_data); end
    step();
    n_cmp++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL rsvd_sel_r10 got=%h exp=0", rs_data); end
    n_cmp++; if (commit_count !== 32'd6) begin n_fail++; $display("FAIL rsvd_count got=%0d exp=6", commit_count); end
  endtask

  task automatic test_wrap();
    set_wb(1'b1, 2'd2, 2'd2, 32'h0C00_0000, 32'hFFFF_FFFC, 32'h0, 32'h0);
    #1;
    n_cmp++; if (fwd_data !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_fwd got=%h exp=%h", fwd_data, 32'h4); end
    step();
    rs_addr = 5'd31;
    #1;
    n_cmp++; if (rs_data !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_r31 got=%h exp=%h", rs_data, 32'h4); end
    n_cmp++; if (commit_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_cpc got=%h exp=%h", commit_pc, 32'hFFFFFFFC); end
    n_cmp++; if (commit_count !== 32'd7) begin n_fail++; $display("FAIL wrap_count got=%0d exp=7", commit_count); end
  endtask

  task automatic test_reset_write();
    reset = 1'b1;
    set_wb(1'b1, 2'd0, 2'd0, 32'h000D_0000, 32'h0000_0700, 32'h0000_0077, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bubble();
    rs_addr = 5'd13;
    rt_addr = 5'd31;
    #1;
    n_cmp++; if (rs_data !== 32'h0) begin n_fail++; $display("FAIL rstw_r13 got=%h exp=0", rs_data); end
    n_cmp++; if (rt_data !== 32'h0) begin n_fail++; $display("FAIL rstw_r31 got=%h exp=0", rt_data); end
    n_cmp++; if (commit_count !== 32'd0) begin n_fail++; $display("FAIL rstw_count got=%0d exp=0", commit_count); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_valid got=%b exp=0", commit_valid); end
    set_wb(1'b1, 2'd0, 2'd0, 32'h000D_0000, 32'h0000_0704, 32'h0000_0088, 32'h0);
    step();
    n_cmp++; if (rs_data !== 32'h0000_0088) begin n_fail++; $display("FAIL rstw_resume_r13 got=%h exp=%h", rs_data, 32'h88); end
    n_cmp++; if (commit_count !== 32'd1) begin n_fail++; $display("FAIL rstw_resume_count got=%0d exp=1", commit_count); end
  endtask

  task automatic test_back_to_back();
    // $1 <- 0x10, $2 <- 0x20 on consecutive edges, reading $1 while $2 is in WB
    set_wb(1'b1, 2'd0, 2'd0, 32'h0001_0000, 32'h0000_0800, 32'h0000_0010, 32'h0);
    @(posedge clk);
    #1;
    set_wb(1'b1, 2'd1, 2'd0, 32'h0002_0000, 32'h0000_0804, 32'h0, 32'h0000_0020);
    rs_addr = 5'd1;
    rt_addr = 5'd2;
    #1;
    n_cmp++; if (commit_addr !== 5'd1 || commit_data !== 32'h10) begin
      n_fail++; $display("FAIL b2b_commit1 got=%0d/%h exp=1/10", commit_addr, commit_data); end
    n_cmp++; if (rs_data !== 32'h10 || rt_data !== 32'h20) begin
      n_fail++; $display("FAIL b2b_reads got=%h/%h exp=10/20", rs_data, rt_data); end
    step();
    n_cmp++; if (commit_valid !== 1'b1 || commit_addr !== 5'd2 || commit_pc !== 32'h0000_0804) begin
      n_fail++; $display("FAIL b2b_commit2 got=%b/%0d/%h exp=1/2/804", commit_valid, commit_addr, commit_pc); end
    n_cmp++; if (commit_count !== 32'd3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", commit_count); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_ori();
    test_jal();
    test_bypass();
    test_zero();
    test_rd_and_reserved();
    test_wrap();
    test_reset_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
